// File: rtl/mc_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mc_control_fsm: multicycle FETCH/DECODE/EXEC/MEM/WB control unit with    |
// | ready handshakes, minimum MEM dwell, HALT/unstop. Optional: PERF_CNT_EN  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mc_control_fsm #(
  parameter int                OPC_W    = 6,
  parameter int                FUNC_W   = 4,
  parameter int                MEM_WAIT = 2,
  parameter logic [OPC_W-1:0]  HALT_OPC = 6'b011110,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              unstop,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic              imem_rdy,
  input  logic              dmem_rdy,
  output logic              irLd,
  output logic [2:0]        brOp,
  output logic [3:0]        aluOp,
  output logic [1:0]        regISel,
  output logic              BSel,
  output logic              wrRegSel,
  output logic              sgnExt,
  output logic              isMV,
  output logic              memRd,
  output logic              memWr,
  output logic              regRd,
  output logic              regWr,
  output logic              incPC,
  output logic              halted,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam logic [2:0] c_RESET  = 3'd7;
  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd5;
  localparam logic [2:0] c_HALT   = 3'd6;

  localparam int            c_CW        = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(MEM_WAIT - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_nextState;
  logic [OPC_W-1:0]  r_opQ;
  logic [FUNC_W-1:0] r_funcQ;
  logic [c_CW-1:0]   r_waitCnt;
  logic              r_fromHalt;

  logic w_i0, w_i17, w_i18, w_i19, w_i28;

  assign w_i0  = (r_opQ == '0);
  assign w_i17 = (r_opQ == OPC_W'(17));
  assign w_i18 = (r_opQ == OPC_W'(18));
  assign w_i19 = (r_opQ == OPC_W'(19));
  assign w_i28 = (r_opQ == OPC_W'(28));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_RESET;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = c_FETCH;
    case (r_state)
      c_RESET:  w_nextState = c_FETCH;
      c_FETCH:  w_nextState = imem_rdy ? c_DECODE : c_FETCH;
      c_DECODE: w_nextState = ((opcode == HALT_OPC) && !unstop) ? c_HALT : c_EXEC;
      c_EXEC:   w_nextState = (w_i18 || w_i19) ? c_MEM : c_WB;
      c_MEM:    w_nextState = ((r_waitCnt == c_WAIT_LAST) && dmem_rdy) ? c_WB : c_MEM;
      c_WB:     w_nextState = c_FETCH;
      c_HALT:   w_nextState = unstop ? c_WB : c_HALT;
      default:  w_nextState = c_FETCH;
    endcase
  end

  // r_fromHalt marks the WB that follows HALT, where op_q still holds the
  // previous instruction and must not write the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opQ      <= '0;
      r_funcQ    <= '0;
      r_waitCnt  <= '0;
      r_fromHalt <= 1'b0;
    end else begin
      if ((r_state == c_DECODE) && (w_nextState == c_EXEC)) begin
        r_opQ   <= opcode;
        r_funcQ <= func;
      end
      if (r_state != c_MEM) begin
        r_waitCnt <= '0;
      end else if (r_waitCnt != c_WAIT_LAST) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
      r_fromHalt <= (r_state == c_HALT);
    end
  end

  always_comb begin
    irLd     = 1'b0;
    regRd    = 1'b0;
    memRd    = 1'b0;
    memWr    = 1'b0;
    regWr    = 1'b0;
    incPC    = 1'b0;
    halted   = 1'b0;
    state_o  = r_state;
    brOp     = r_opQ[5] ? r_opQ[2:0] : 3'd0;
    aluOp    = w_i0 ? 4'(r_funcQ) : r_opQ[3:0];
    regISel  = {w_i17 | w_i28, w_i17 | w_i18};
    BSel     = w_i0 | w_i28;
    wrRegSel = w_i0 | w_i28;
    sgnExt   = r_opQ[5] | (r_opQ[4] & r_opQ[3]);
    isMV     = w_i28;
    case (r_state)
      c_FETCH: irLd  = 1'b1;
      c_EXEC:  regRd = 1'b1;
      c_MEM: begin
        memRd = w_i18;
        memWr = w_i19;
      end
      c_WB: begin
        regWr = (~r_opQ[4] | w_i17 | w_i18 | w_i28) & ~r_fromHalt;
        incPC = 1'b1;
      end
      c_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_instrCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instrCnt <= '0;
    end else if (r_state == c_WB) begin
      r_instrCnt <= r_instrCnt + 1'b1;
    end
  end

  assign instr_cnt = r_instrCnt;
`else
  assign instr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mc_control_fsm: table vectors, corner sequences and random programs   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mc_control_fsm;

  localparam int         MW   = 2;
  localparam logic [5:0] HALT = 6'b011110;

  logic clk = 1'b0;
  logic rst, unstop, imemRdy, dmemRdy;
  logic [5:0] opcode;
  logic [3:0] func;
  logic irLd, BSel, wrRegSel, sgnExt, isMV, memRd, memWr, regRd, regWr, incPC, halted;
  logic [2:0] brOp, state_o;
  logic [3:0] aluOp;
  logic [1:0] regISel;
  logic [31:0] instr_cnt;

  logic rst2, unstop2, imemRdy2, dmemRdy2;
  logic [5:0] opcode2;
  logic [3:0] func2;
  logic irLd2, BSel2, wrRegSel2, sgnExt2, isMV2, memRd2, memWr2, regRd2, regWr2, incPC2, halted2;
  logic [2:0] brOp2, state2;
  logic [3:0] aluOp2;
  logic [1:0] regISel2;
  logic [31:0] instrCnt2;

  int nChecks = 0;
  int nFail   = 0;

  logic [5:0]  mOp;
  logic [3:0]  mFn;
  logic [31:0] mCnt;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .unstop(unstop), .opcode(opcode), .func(func),
    .imem_rdy(imemRdy), .dmem_rdy(dmemRdy), .irLd(irLd), .brOp(brOp), .aluOp(aluOp),
    .regISel(regISel), .BSel(BSel), .wrRegSel(wrRegSel), .sgnExt(sgnExt), .isMV(isMV),
    .memRd(memRd), .memWr(memWr), .regRd(regRd), .regWr(regWr), .incPC(incPC),
    .halted(halted), .state_o(state_o), .instr_cnt(instr_cnt)
  );

  mc_control_fsm #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .rst(rst2), .unstop(unstop2), .opcode(opcode2), .func(func2),
    .imem_rdy(imemRdy2), .dmem_rdy(dmemRdy2), .irLd(irLd2), .brOp(brOp2), .aluOp(aluOp2),
    .regISel(regISel2), .BSel(BSel2), .wrRegSel(wrRegSel2), .sgnExt(sgnExt2), .isMV(isMV2),
    .memRd(memRd2), .memWr(memWr2), .regRd(regRd2), .regWr(regWr2), .incPC(incPC2),
    .halted(halted2), .state_o(state2), .instr_cnt(instrCnt2)
  );

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  fn;
    logic [12:0] dec;
    logic        wr;
    int          cycles;
    int          memCycles;
  } vec_t;

  vec_t tbl[10];

  // Decode packing: {brOp, aluOp, regISel, BSel, wrRegSel, sgnExt, isMV}
  function automatic logic [12:0] decM(input logic [5:0] o, input logic [3:0] f);
    logic [2:0] br;
    logic [3:0] alu;
    logic [1:0] rs;
    logic       b, se, mv;
    br  = o[5] ? o[2:0] : 3'd0;
    alu = (o == 6'd0) ? f : o[3:0];
    rs  = {(o == 6'd17) || (o == 6'd28), (o == 6'd17) || (o == 6'd18)};
    b   = (o == 6'd0) || (o == 6'd28);
    se  = o[5] | (o[4] & o[3]);
    mv  = (o == 6'd28);
    return {br, alu, rs, b, b, se, mv};
  endfunction

  function automatic logic wbWr(input logic [5:0] o);
    return ~o[4] | (o == 6'd17) | (o == 6'd18) | (o == 6'd28);
  endfunction

  function automatic logic [9:0] mk(input logic [2:0] s, input logic ir, input logic rr,
                                    input logic mr, input logic mw, input logic rw,
                                    input logic ip, input logic h);
    return {s, ir, rr, mr, mw, rw, ip, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [9:0] ctl);
    logic [9:0]  gotCtl;
    logic [12:0] gotDec;
    logic [31:0] expCnt;
    gotCtl = {state_o, irLd, regRd, memRd, memWr, regWr, incPC, halted};
    gotDec = {brOp, aluOp, regISel, BSel, wrRegSel, sgnExt, isMV};
`ifdef PERF_CNT_EN
    expCnt = mCnt;
`else
    expCnt = 32'd0;
`endif
    nChecks++;
    if (gotCtl !== ctl) begin
      nFail++;
      $display("FAIL %s ctrl {state,irLd,regRd,memRd,memWr,regWr,incPC,halted}: got %b required %b",
               nm, gotCtl, ctl);
    end
    nChecks++;
    if (gotDec !== decM(mOp, mFn)) begin
      nFail++;
      $display("FAIL %s decode: got %b required %b", nm, gotDec, decM(mOp, mFn));
    end
    nChecks++;
    if (instr_cnt !== expCnt) begin
      nFail++;
      $display("FAIL %s instr_cnt: got %0d required %0d", nm, instr_cnt, expCnt);
    end
  endtask

  // Expected trace built from the instruction's phase lengths.
  // hm: 1 = halt opcode with unstop in DECODE (NOP), 2 = stop in HALT for hc cycles.
  task automatic run_instr(input logic [5:0] op, input logic [3:0] fn, input int fst,
                           input int dw, input int hm, input int hc);
    int n;
    opcode = op;
    func   = fn;
    for (int i = 0; i <= fst; i++) begin
      imemRdy = (i == fst);
      dmemRdy = 1'($urandom);
      unstop  = 1'($urandom);
      chk("fetch", mk(3'd0, 1, 0, 0, 0, 0, 0, 0));
      tick();
    end
    imemRdy = 1'($urandom);
    unstop  = (op == HALT) ? (hm == 1) : 1'($urandom);
    chk("decode", mk(3'd1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    if (op == HALT && hm != 1) begin
      for (int i = 0; i < hc; i++) begin
        unstop = (i == hc - 1);
        chk("halt", mk(3'd6, 0, 0, 0, 0, 0, 0, 1));
        tick();
      end
      unstop = 1'($urandom);
      chk("wb_after_halt", mk(3'd5, 0, 0, 0, 0, 0, 1, 0));
      tick();
      mCnt++;
    end else begin
      mOp = op;
      mFn = fn;
      unstop = 1'($urandom);
      chk("exec", mk(3'd2, 0, 1, 0, 0, 0, 0, 0));
      tick();
      if (op == 6'd18 || op == 6'd19) begin
        n = (dw + 1 > MW) ? dw + 1 : MW;
        for (int i = 0; i < n; i++) begin
          dmemRdy = (i >= dw);
          chk("mem", mk(3'd3, 0, 0, op == 6'd18, op == 6'd19, 0, 0, 0));
          tick();
        end
      end
      chk("wb", mk(3'd5, 0, 0, 0, 0, wbWr(op), 1, 0));
      tick();
      mCnt++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, memc, wr2cnt;
    logic [12:0] gotDec;
    logic gotWr, wb2Wr;

    tbl[0] = '{6'd0,  4'd3, {3'd0, 4'd3,  2'b00, 1'b1, 1'b1, 1'b0, 1'b0}, 1'b1, 4, 0};
    tbl[1] = '{6'd18, 4'd5, {3'd0, 4'd2,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 6, 2};
    tbl[2] = '{6'd19, 4'd9, {3'd0, 4'd3,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0, 6, 2};
    tbl[3] = '{6'd17, 4'd7, {3'd0, 4'd1,  2'b11, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 4, 0};
    tbl[4] = '{6'd28, 4'd2, {3'd0, 4'd12, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1}, 1'b1, 4, 0};
    tbl[5] = '{6'd37, 4'd0, {3'd5, 4'd5,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1, 4, 0};
    tbl[6] = '{6'd51, 4'd1, {3'd3, 4'd3,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0, 4, 0};
    tbl[7] = '{6'd10, 4'd4, {3'd0, 4'd10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, 4, 0};
    tbl[8] = '{HALT,  4'd6, {3'd0, 4'd14, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0, 4, 0};
    tbl[9] = '{6'd24, 4'd8, {3'd0, 4'd8,  2'b00, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0, 4, 0};

    rst = 1; unstop = 0; imemRdy = 0; dmemRdy = 0; opcode = '0; func = '0;
    rst2 = 1; unstop2 = 0; imemRdy2 = 1; dmemRdy2 = 1; opcode2 = 6'd19; func2 = '0;
    mOp = '0; mFn = '0; mCnt = '0;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset", mk(3'd7, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("reset_held", mk(3'd7, 0, 0, 0, 0, 0, 0, 0));
    rst = 0;
    tick();

    for (int i = 0; i < 10; i++) begin
      opcode = tbl[i].op; func = tbl[i].fn;
      imemRdy = 1; dmemRdy = 1; unstop = (tbl[i].op == HALT);
      cyc = 0; memc = 0; gotDec = 'x; gotWr = 1'bx;
      for (int k = 0; k < 30; k++) begin
        if (state_o == 3'd5) begin
          gotDec = {brOp, aluOp, regISel, BSel, wrRegSel, sgnExt, isMV};
          gotWr  = regWr;
        end
        if (memRd || memWr) memc++;
        cyc++;
        tick();
        if (state_o == 3'd0) break;
      end
      nChecks++;
      if (cyc != tbl[i].cycles) begin
        nFail++;
        $display("FAIL tbl%0d latency: got %0d required %0d", i, cyc, tbl[i].cycles);
      end
      nChecks++;
      if (memc != tbl[i].memCycles) begin
        nFail++;
        $display("FAIL tbl%0d mem strobe cycles: got %0d required %0d", i, memc, tbl[i].memCycles);
      end
      nChecks++;
      if (gotDec !== tbl[i].dec) begin
        nFail++;
        $display("FAIL tbl%0d decode: got %b required %b", i, gotDec, tbl[i].dec);
      end
      nChecks++;
      if (gotWr !== tbl[i].wr) begin
        nFail++;
        $display("FAIL tbl%0d wb regWr: got %b required %b", i, gotWr, tbl[i].wr);
      end
      mOp = tbl[i].op; mFn = tbl[i].fn; mCnt++;
    end

    run_instr(6'd0, 4'b0011, 0, 0, 0, 0);
    run_instr(6'd18, 4'd0, 0, 3, 0, 0);
    run_instr(HALT, 4'd0, 0, 0, 2, 11);
    run_instr(6'd0, 4'd9, 5, 0, 0, 0);

    // Reset in the second MEM cycle of a load
    opcode = 6'd18; func = 4'd1; imemRdy = 1; dmemRdy = 0; unstop = 0;
    chk("mr_fetch", mk(3'd0, 1, 0, 0, 0, 0, 0, 0));
    tick();
    chk("mr_decode", mk(3'd1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    mOp = 6'd18; mFn = 4'd1;
    chk("mr_exec", mk(3'd2, 0, 1, 0, 0, 0, 0, 0));
    tick();
    chk("mr_mem1", mk(3'd3, 0, 0, 1, 0, 0, 0, 0));
    tick();
    rst = 1;
    chk("mr_mem2", mk(3'd3, 0, 0, 1, 0, 0, 0, 0));
    tick();
    mOp = '0; mFn = '0; mCnt = '0;
    chk("mr_reset", mk(3'd7, 0, 0, 0, 0, 0, 0, 0));
    rst = 0;
    tick();

    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      int hm;
      case ($urandom_range(0, 5))
        0:       op = 6'd18;
        1:       op = 6'd19;
        2:       op = HALT;
        default: op = 6'($urandom);
      endcase
      hm = (op == HALT) ? int'($urandom_range(1, 2)) : 0;
      run_instr(op, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                hm, int'($urandom_range(1, 4)));
    end

    // Store on a MEM_WAIT=3 instance with data memory always ready
    nChecks++;
    if (state2 !== 3'd7) begin
      nFail++;
      $display("FAIL st3 reset state: got %0d required 7", state2);
    end
    rst2 = 0;
    tick();
    cyc = 0; wr2cnt = 0; wb2Wr = 1'bx;
    for (int k = 0; k < 30; k++) begin
      if (memWr2) wr2cnt++;
      if (state2 == 3'd5) wb2Wr = regWr2;
      cyc++;
      tick();
      if (state2 == 3'd0) break;
    end
    nChecks++;
    if (wr2cnt != 3) begin
      nFail++;
      $display("FAIL st3 memWr cycles: got %0d required 3", wr2cnt);
    end
    nChecks++;
    if (cyc != 7) begin
      nFail++;
      $display("FAIL st3 latency: got %0d required 7", cyc);
    end
    nChecks++;
    if (wb2Wr !== 1'b0) begin
      nFail++;
      $display("FAIL st3 wb regWr: got %b required 0", wb2Wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
